// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-compare helper for the synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_ADDR_W_DEF = 5;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

    // Pointers carry one extra wrap bit; the modular difference is the occupancy.
    function automatic fifo_flags_t ptr_flags(input logic [31:0] wr_ptr,
                                              input logic [31:0] rd_ptr,
                                              input int          addr_w);
        logic [31:0] mask;
        logic [31:0] diff;
        fifo_flags_t f;
        mask    = (32'd1 << (addr_w + 1)) - 32'd1;
        diff    = (wr_ptr - rd_ptr) & mask;
        f.empty = (diff == 32'd0);
        f.full  = (diff == (32'd1 << addr_w));
        return f;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Dual-port register-file RAM: synchronous write, synchronous registered read.
// Only the read register is reset; the storage array is not.
module fifo_ram_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO over fifo_ram_2p with chip-select gated push/pop, occupancy and flags.
// Define FIFO_ERR_FLAGS_EN to add sticky Overflow/Underflow outputs.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_W_DEF,
    parameter int ADDR_WIDTH = FIFO_ADDR_W_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Chip_Select,
    input  logic                  Write_Enable,
    input  logic                  Read_Enable,
    input  logic [DATA_WIDTH-1:0] Data,
    output logic [DATA_WIDTH-1:0] Output,
    output logic                  Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  Overflow,
    output logic                  Underflow
`endif
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t        wr_ptr_d, wr_ptr_q;
    ptr_t        rd_ptr_d, rd_ptr_q;
    ptr_t        count_d,  count_q;
    logic        full_q,   empty_q;
    logic        valid_d,  valid_q;
    logic        push_ok,  pop_ok;
    fifo_flags_t flags_d;

    always_comb begin
        push_ok  = Chip_Select & Write_Enable & ~full_q;
        pop_ok   = Chip_Select & Read_Enable & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + PTR_W'(1);
            2'b01:   count_d = count_q - PTR_W'(1);
            default: count_d = count_q;
        endcase
        // Flags come from next-state pointers so they track Count in the same cycle.
        flags_d = ptr_flags(32'(wr_ptr_d), 32'(rd_ptr_d), ADDR_WIDTH);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= flags_d.full;
            empty_q  <= flags_d.empty;
            valid_q  <= valid_d;
        end
    end

    // Full/empty gating guarantees the read and write addresses never collide.
    fifo_ram_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (Data),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (Output)
    );

    assign Valid = valid_q;
    assign Full  = full_q;
    assign Empty = empty_q;
    assign Count = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_d, ovf_q;
    logic unf_d, unf_q;

    always_comb begin
        ovf_d = ovf_q | (Chip_Select & Write_Enable & full_q);
        unf_d = unf_q | (Chip_Select & Read_Enable & empty_q);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench for sync_fifo_ram against a queue-based reference model.
// Error-flag scenarios are included when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_ram;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Chip_Select = 1'b0;
    logic          Write_Enable = 1'b0;
    logic          Read_Enable = 1'b0;
    logic [DW-1:0] Data = '0;
    logic [DW-1:0] Output;
    logic          Valid;
    logic          Full;
    logic          Empty;
    logic [AW:0]   Count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          Overflow;
    logic          Underflow;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_out = '0;
    logic          exp_valid = 1'b0;

    sync_fifo_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Chip_Select  (Chip_Select),
        .Write_Enable (Write_Enable),
        .Read_Enable  (Read_Enable),
        .Data         (Data),
        .Output       (Output),
        .Valid        (Valid),
        .Full         (Full),
        .Empty        (Empty),
        .Count        (Count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .Overflow     (Overflow),
        .Underflow    (Underflow)
`endif
    );

    always #5 Clock = ~Clock;

    // Drive one cycle and advance the reference model; sampling is left to the caller.
    task automatic drive_cycle(input logic cs, input logic we, input logic re, input logic [DW-1:0] d);
        bit push_ok, pop_ok;
        @(negedge Clock);
        Chip_Select  = cs;
        Write_Enable = we;
        Read_Enable  = re;
        Data         = d;
        push_ok = cs && we && (mq.size() < DEPTH);
        pop_ok  = cs && re && (mq.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
        if (cs && we && mq.size() == DEPTH) exp_ovf = 1'b1;
        if (cs && re && mq.size() == 0)     exp_unf = 1'b1;
`endif
        @(posedge Clock);
        if (pop_ok) begin
            exp_out   = mq.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (push_ok) mq.push_back(d);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        mq.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        #1;
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Chip_Select  = 1'b0;
        Write_Enable = 1'b0;
        Read_Enable  = 1'b0;
        Reset_n      = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (Count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", Count); end
        checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL rst_flags: got E=%b F=%b want E=1 F=0", Empty, Full); end
        checks++; if (Valid !== 1'b0 || Output !== '0) begin errors++; $display("FAIL rst_out: got V=%b O=%h want V=0 O=00", Valid, Output); end
        release_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1, 1, 0, 8'($urandom_range(1, 255)) | 8'h01);
        drive_cycle(1, 0, 1, 8'h00);
        checks++; if (Count !== 6'd5 || Output !== exp_out) begin errors++; $display("FAIL pre_rst: got C=%0d O=%h want C=5 O=%h", Count, Output, exp_out); end
        apply_reset();
        checks++; if (Count !== '0 || Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL async_rst_state: got C=%0d E=%b F=%b want 0/1/0", Count, Empty, Full); end
        checks++; if (Valid !== 1'b0 || Output !== '0) begin errors++; $display("FAIL async_rst_out: got V=%b O=%h want 0/00", Valid, Output); end
        release_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1, 1, 0, 8'(i));
            checks++; if (Count !== 6'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, Count, i); end
            checks++; if (Full !== (i == DEPTH) || Empty !== 1'b0) begin errors++; $display("FAIL fill_flags[%0d]: got F=%b E=%b", i, Full, Empty); end
        end
        drive_cycle(1, 1, 0, 8'hFF);
        checks++; if (Count !== 6'd32 || Full !== 1'b1) begin errors++; $display("FAIL push_full: got C=%0d F=%b want 32/1", Count, Full); end
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1, 0, 1, 8'h00);
            checks++; if (Valid !== 1'b1 || Output !== 8'(i)) begin errors++; $display("FAIL drain[%0d]: got V=%b O=%h want 1/%h", i, Valid, Output, 8'(i)); end
            checks++; if (Count !== 6'(DEPTH - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, Count, DEPTH - i); end
        end
        checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL drain_flags: got E=%b F=%b want 1/0", Empty, Full); end
        drive_cycle(1, 0, 0, 8'h00);
        checks++; if (Valid !== 1'b0 || Output !== 8'h20) begin errors++; $display("FAIL hold: got V=%b O=%h want 0/20", Valid, Output); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= DEPTH; i++) drive_cycle(1, 1, 0, 8'(i));
        drive_cycle(1, 1, 1, 8'hAA);
        checks++; if (Output !== 8'h01 || Valid !== 1'b1) begin errors++; $display("FAIL full_pp_out: got V=%b O=%h want 1/01", Valid, Output); end
        checks++; if (Count !== 6'd31 || Full !== 1'b0) begin errors++; $display("FAIL full_pp_count: got C=%0d F=%b want 31/0", Count, Full); end
        for (int i = 2; i <= DEPTH; i++) begin
            drive_cycle(1, 0, 1, 8'h00);
            checks++; if (Output !== exp_out || Output !== 8'(i)) begin errors++; $display("FAIL full_pp_drain[%0d]: got %h want %h", i, Output, 8'(i)); end
        end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL full_pp_empty: got %b want 1", Empty); end
        drive_cycle(1, 1, 1, 8'h5C);
        checks++; if (Count !== 6'd1 || Valid !== 1'b0 || Empty !== 1'b0) begin errors++; $display("FAIL empty_pp: got C=%0d V=%b E=%b want 1/0/0", Count, Valid, Empty); end
        drive_cycle(1, 0, 1, 8'h00);
        checks++; if (Output !== 8'h5C || Valid !== 1'b1) begin errors++; $display("FAIL empty_pp_pop: got V=%b O=%h want 1/5c", Valid, Output); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pat;
        pat = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 1, 0, pat);
            pat = pat + 8'd1;
        end
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1, 1, 1, pat);
            checks++; if (Count !== 6'd10) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 10", i, Count); end
            checks++; if (Valid !== 1'b1 || Output !== 8'(pat - 8'd10)) begin errors++; $display("FAIL b2b_out[%0d]: got V=%b O=%h want 1/%h", i, Valid, Output, 8'(pat - 8'd10)); end
            pat = pat + 8'd1;
        end
    endtask

    task automatic test_cs_low();
        logic [DW-1:0] held;
        logic [AW:0]   cnt;
        drive_cycle(1, 0, 0, 8'h00);
        held = exp_out;
        cnt  = 6'(mq.size());
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, 1, 1, 8'($urandom));
            checks++; if (Count !== cnt || Output !== held || Valid !== 1'b0) begin errors++; $display("FAIL cs_low[%0d]: got C=%0d O=%h V=%b want %0d/%h/0", i, Count, Output, Valid, cnt, held); end
        end
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 0, 1, 8'h00);
            checks++; if (Output !== exp_out) begin errors++; $display("FAIL cs_low_drain[%0d]: got %h want %h", i, Output, exp_out); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom % 8) != 0, ($urandom % 2) == 0, ($urandom % 3) == 0 || i > 300, 8'($urandom));
            checks++; if (Count !== 6'(mq.size()) || Full !== (mq.size() == DEPTH) || Empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_state[%0d]: got C=%0d F=%b E=%b want C=%0d", i, Count, Full, Empty, mq.size()); end
            checks++; if (Valid !== exp_valid || Output !== exp_out) begin errors++; $display("FAIL rand_out[%0d]: got V=%b O=%h want %b/%h", i, Valid, Output, exp_valid, exp_out); end
        end
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        apply_reset();
        release_reset();
        drive_cycle(1, 0, 1, 8'h00);
        checks++; if (Underflow !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL unf_set: got U=%b O=%b want 1/0", Underflow, Overflow); end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1, 1, 0, 8'($urandom));
        checks++; if (Underflow !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL unf_sticky: got U=%b O=%b want 1/0", Underflow, Overflow); end
        drive_cycle(1, 1, 0, 8'h77);
        checks++; if (Overflow !== exp_ovf || Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", Overflow); end
        drive_cycle(1, 0, 1, 8'h00);
        checks++; if (Overflow !== 1'b1 || Underflow !== 1'b1) begin errors++; $display("FAIL err_sticky: got O=%b U=%b want 1/1", Overflow, Underflow); end
        apply_reset();
        checks++; if (Overflow !== 1'b0 || Underflow !== 1'b0) begin errors++; $display("FAIL err_rst: got O=%b U=%b want 0/0", Overflow, Underflow); end
        release_reset();
    endtask
`endif

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_back_to_back();
        test_cs_low();
        test_random();
`ifdef FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
